// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - shared types, direction indices and defaults for input_conditioner
package input_pkg;

  typedef enum logic {
    READY    = 1'b0,
    COOLDOWN = 1'b1
  } shoot_state_t;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int DEFAULT_COOLDOWN_CYCLES = 12500000;

  // Keep only the highest-priority pressed direction: up > down > left > right.
  function automatic logic [3:0] priority_mask(input logic [3:0] dirs);
    priority_mask = 4'b0000;
    if (dirs[DIR_UP])         priority_mask[DIR_UP]    = 1'b1;
    else if (dirs[DIR_DOWN])  priority_mask[DIR_DOWN]  = 1'b1;
    else if (dirs[DIR_LEFT])  priority_mask[DIR_LEFT]  = 1'b1;
    else if (dirs[DIR_RIGHT]) priority_mask[DIR_RIGHT] = 1'b1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-flop synchroniser plus counter debouncer for one raw button
module button_debounce
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] count;

  // Any sample equal to the stable level restarts the run, so bounces never accumulate.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      stable_o <= 1'b0;
      count    <= '0;
    end else begin
      meta <= raw_i;
      sync <= meta;
      if (sync == stable_o) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        stable_o <= sync;
        count    <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced, direction-masked moves and rate-limited fire pulses for two players
module input_conditioner
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEFAULT_COOLDOWN_CYCLES
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] player_1_move_raw_i,
  input  logic [3:0] player_2_move_raw_i,
  input  logic       player_1_shoot_raw_i,
  input  logic       player_2_shoot_raw_i,
  output logic [3:0] player_1_move_o,
  output logic [3:0] player_2_move_o,
  output logic       player_1_shoot_o,
  output logic       player_2_shoot_o
);

  localparam int CCW = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [CCW-1:0] COOL_LOAD = CCW'(COOLDOWN_CYCLES - 1);

  logic [9:0] raw;
  logic [9:0] stable;

  // Bit map: [3:0] p1 move, [7:4] p2 move, [8] p1 shoot, [9] p2 shoot.
  assign raw = {player_2_shoot_raw_i, player_1_shoot_raw_i,
                player_2_move_raw_i, player_1_move_raw_i};

  for (genvar i = 0; i < 10; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .raw_i    (raw[i]),
      .stable_o (stable[i])
    );
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      player_1_move_o <= 4'b0000;
      player_2_move_o <= 4'b0000;
    end else begin
      player_1_move_o <= priority_mask(stable[3:0]);
      player_2_move_o <= priority_mask(stable[7:4]);
    end
  end

  logic [1:0] shoot_prev;
  logic [1:0] rise;
  logic [1:0] fire;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shoot_prev <= 2'b00;
      rise       <= 2'b00;
    end else begin
      shoot_prev <= stable[9:8];
      rise       <= stable[9:8] & ~shoot_prev;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_shoot
    shoot_state_t   state;
    shoot_state_t   state_next;
    logic [CCW-1:0] cool;
    logic [CCW-1:0] cool_next;
    logic           fire_q;
    logic           fire_next;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        state  <= READY;
        cool   <= '0;
        fire_q <= 1'b0;
      end else begin
        state  <= state_next;
        cool   <= cool_next;
        fire_q <= fire_next;
      end
    end

    // A rise seen while cooling down is simply lost; it is never remembered.
    always_comb begin
      state_next = state;
      cool_next  = cool;
      fire_next  = 1'b0;
      case (state)
        READY: begin
          if (rise[p]) begin
            fire_next  = 1'b1;
            cool_next  = COOL_LOAD;
            state_next = COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (cool == '0) state_next = READY;
          else            cool_next  = cool - CCW'(1);
        end
        default: state_next = READY;
      endcase
    end

    assign fire[p] = fire_q;
  end

  assign player_1_shoot_o = fire[0];
  assign player_2_shoot_o = fire[1];

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioning stage for the tank game. Sits directly upstream of the game top level and drives its `player_1_move_i`, `player_2_move_i`, `player_1_shoot_i` and `player_2_shoot_i` inputs. It synchronises and debounces the ten raw button lines, masks the move buttons to a single active direction per player, and converts each shoot button into a single-cycle fire pulse with a per-player cooldown.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive cycles a synchronised input must differ from its stable value before the stable value flips (10 ms at 25 MHz).
- `COOLDOWN_CYCLES`, default 12500000: cycles a player's shoot channel stays locked after a fire pulse (0.5 s at 25 MHz).
- `clk_i`, in, 1: pixel clock. This is the only clock.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `player_1_move_raw_i`, in, 4: raw player 1 direction buttons, bit 3..0, asynchronous to `clk_i`.
- `player_2_move_raw_i`, in, 4: raw player 2 direction buttons.
- `player_1_shoot_raw_i`, in, 1: raw player 1 fire button.
- `player_2_shoot_raw_i`, in, 1: raw player 2 fire button.
- `player_1_move_o`, out, 4: debounced player 1 direction, registered, at most one bit set.
- `player_2_move_o`, out, 4: debounced player 2 direction, same rules as player 1.
- `player_1_shoot_o`, out, 1: single-cycle fire pulse for player 1.
- `player_2_shoot_o`, out, 1: single-cycle fire pulse for player 2.

## Operation
- **Per-button path (10 identical instances):**
  - A 2-flop synchroniser produces `sync`.
  - `stable` holds the debounced level and resets to 0.
  - A counter of width $clog2(DEBOUNCE_CYCLES+1) runs as follows:
    - `sync == stable`: counter clears to 0.
    - `sync != stable` and counter < DEBOUNCE_CYCLES-1: counter increments.
    - `sync != stable` and counter == DEBOUNCE_CYCLES-1: `stable <= sync` and the counter clears.
  - Any bounce back to the `stable` value restarts the count from 0.
- **Move mask (per player):**
  - Registered priority select on the 4 `stable` bits, bit 3 > 2 > 1 > 0.
  - Only the highest set bit is passed; all others read 0.
  - All bits released gives 4'b0000.
- **Shoot FSM (per player):**
  - States are READY and COOLDOWN; reset state is READY.
  - `rise` is the registered detection of a `stable` 0→1 transition.
  - READY and `rise`: `shoot_o` = 1 for one cycle, cooldown counter loads COOLDOWN_CYCLES-1, next state COOLDOWN.
  - COOLDOWN: if counter == 0, go to READY; otherwise decrement.
  - A `rise` during COOLDOWN is dropped. It is not queued.
  - Holding the button never auto-repeats. A new fire requires release and press again, each debounced.
- The two players are fully independent. Simultaneous events on both players are each handled normally.
- A button held through reset release debounces to 1 after reset and produces exactly one fire pulse.
- Edge cases:
  - DEBOUNCE_CYCLES must be ≥ 1.
  - COOLDOWN_CYCLES must be ≥ 1.

## Timing
- **Reset:**
  - While `reset_i` is high, every output is 0 immediately (asynchronous).
  - While `reset_i` is high, all synchronisers, `stable` registers and counters are 0, and both FSMs are in READY.
  - A reset asserted mid-debounce or mid-cooldown discards that state entirely.
- **Sync latency:** a raw change sampled at edge E appears on `sync` after edge E+1.
- **Debounce latency:** `stable` flips at edge E+1+DEBOUNCE_CYCLES, provided `sync` stays constant.
- **Move latency:** `move_o` updates at edge E+2+DEBOUNCE_CYCLES.
  - Total: DEBOUNCE_CYCLES+2 edges after the first sampling edge.
  - Press and release have the same latency.
- **Shoot latency:** `rise` is registered one edge after `stable` flips, and `shoot_o` is registered one edge after that.
  - The pulse is high during the cycle after edge E+3+DEBOUNCE_CYCLES.
- **Fire spacing:** the minimum spacing between two pulses from the same player is COOLDOWN_CYCLES+1 cycles.
  - A `rise` arriving exactly on the cycle the FSM returns to READY is accepted.

## Structure
- **Package `input_pkg`:**
  - `shoot_state_t` enum {READY, COOLDOWN}.
  - Direction bit index constants: DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0.
  - Default DEBOUNCE_CYCLES and COOLDOWN_CYCLES localparams.
- **Sub-module `button_debounce`:**
  - Contains the synchroniser, `stable` register and counter.
  - Parameterised by DEBOUNCE_CYCLES; ports `clk_i`, `reset_i`, `raw_i`, `stable_o`.
  - Instantiated 10 times.
- **Top of this block:** holds the two move masks and the two shoot FSMs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8.
- **Reset:** assert `reset_i` asynchronously mid-debounce and mid-cooldown → all outputs 0 at once. After release, a press held steady gives the full latency again, not a shortened one.
- **Clean move press:** `player_1_move_raw_i` = 4'b0100 at edge E and held → `player_1_move_o` = 4'b0100 after edge E+6, and 0 before that. Release gives 4'b0000 after the same delay.
- **Bounce:** raw line toggles every 2 cycles for 12 cycles, then stays high → exactly one 0→1 output transition, 6 edges after the last toggle, with no glitches.
- **Multi-direction:** raw 4'b1010 → output 4'b1000. Release bit 3 → 4'b0010 six edges later.
- **Cooldown and hold:**
  - Hold shoot for 50 cycles → exactly one pulse.
  - Re-press 5 cycles after the pulse → no pulse.
  - Re-press so `rise` lands 9 cycles after the pulse → second pulse.
- **Simultaneous players:** both shoot buttons rise at the same edge → both pulses high in the same cycle, with independent cooldowns. Player 2 pressing during player 1's cooldown is still served.
